serial_addsub_seq: RTL and testbench
====================================

Name: serial_addsub_seq

Overview:
- Bit-serial add/subtract engine that sequences a single instance of the team's 1-bit `fullAdder` cell (A, B, cin, s0 → sum, cout) over WIDTH cycles.
- Intended as a low-area ALU alternative for non-critical paths, such as address or offset updates and the multi-cycle unit.
- Owns the operand shift registers, the carry flop, the bit counter and the start/busy/done handshake.
- Produces the result plus condition flags (N, Z, V, C) in the same convention as the pipeline's ALU.

Parameters:
- WIDTH, 64, operand and result width in bits. Legal range is 2 to 64.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. 0 resets the block.
- start  input  1  request a new operation. Sampled only in IDLE.
- op_sub  input  1  0 = A+B, 1 = A-B. Captured with start.
- a  input  WIDTH  operand A. Captured with start.
- b  input  WIDTH  operand B. Captured with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse: result and flags are valid.
- result  output  WIDTH  sum or difference. Held until the next accepted start.
- negative  output  1  result[WIDTH-1].
- zero  output  1  result == 0.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- carry_out  output  1  carry out of the MSB. For subtract, 1 means no borrow.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, done=0, result=0, all flags=0, carry flop=0, counter=0. Takes effect immediately, including mid-operation. An aborted operation leaves no partial result visible.
- States are IDLE, RUN and DONE.
- IDLE:
  - If start=1 at a rising edge (E0), latch a, b and op_sub into shift registers.
  - Set carry flop = op_sub (two's-complement +1 for subtract).
  - Set counter=0, go to RUN, busy=1 from E0.
  - If start=0, stay in IDLE.
- RUN:
  - Each cycle, fullAdder inputs are A=a_sh[0], B=b_sh[0], cin=carry flop, s0=op_sub_q.
  - At each edge: shift a_sh and b_sh right by 1; shift sum into the result shift register's MSB (LSB-first accumulation); carry flop <= fullAdder cout.
  - At the edge for counter==WIDTH-2, additionally capture the fullAdder cout as the carry into the MSB.
  - Counter increments per edge. At the edge where counter==WIDTH-1, the final bit is processed: counter wraps to 0 and the state goes to DONE.
  - Bits are processed at edges E1..EWIDTH, so the result is complete after exactly WIDTH cycles.
- DONE (one cycle, the cycle after EWIDTH):
  - done=1, busy=1.
  - result, negative, zero, overflow and carry_out are all valid and registered. Flags are computed from the completed result register, not combinationally from live inputs.
  - Next edge goes to IDLE with done=0, busy=0. Outputs hold their values.
- start in RUN or DONE is ignored: no queueing and no change to the in-flight operands.
- start asserted at the same edge as the DONE→IDLE transition is ignored. It is accepted only when sampled in the IDLE state.
- a, b and op_sub may change freely after the start edge without affecting the result.
- Latency: start edge to done pulse is WIDTH+1 cycles. Minimum issue interval is WIDTH+2 cycles.
- Arithmetic is modulo 2^WIDTH. carry_out follows the ALU convention: for subtract, carry_out = NOT borrow.
- The clock period must cover the fullAdder path: mux plus 3 gate levels at 50 ps each, plus flop setup.

Optional Feature:
- Macro: SERIAL_ADDSUB_ABORT_EN.
- When defined, an extra input `abort` (1 bit) is added.
  - abort=1 sampled at an edge in RUN forces IDLE at that edge.
  - busy drops the next cycle, no done pulse is issued, and result and flags keep their values from before the start.
  - abort in IDLE or DONE has no effect. abort has priority over the final-bit transition to DONE.
- When not defined, the port does not exist and RUN always completes.

Test Plan:
- WIDTH=8, add, a=0x7F, b=0x01 → done exactly 9 cycles after the start edge; result=0x80, negative=1, zero=0, overflow=1, carry_out=0.
- WIDTH=8, sub, a=0x05, b=0x05 → result=0x00, zero=1, carry_out=1, overflow=0, negative=0.
- WIDTH=8, sub, a=0x00, b=0x01 → result=0xFF, negative=1, carry_out=0 (borrow), overflow=0. Then add 0xFF+0x01 → result=0x00, carry_out=1, zero=1.
- Start held high through RUN with different a/b values → only the first operation executes. Exactly one done pulse; busy continuous for 9 cycles. The next operation is accepted only after returning to IDLE.
- Assert reset=0 mid-RUN, asynchronously between edges → busy, done and result go to 0 immediately with no done pulse. After release, a fresh add 0x03+0x04 gives 0x07.
- With SERIAL_ADDSUB_ABORT_EN: start add 0x10+0x20, pulse abort at the 4th RUN edge → no done pulse, busy low the next cycle, result retains its prior value. A following add completes normally.

Source files
------------

// File: rtl/serial_addsub_seq.sv
// Bit-serial add/subtract engine: one full-adder cell sequenced over WIDTH cycles, ALU-style N/Z/V/C flags.
// Optional abort input enabled by defining SERIAL_ADDSUB_ABORT_EN.
module serial_addsub_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDSUB_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] MSB_CIN  = CNT_W'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The shared 1-bit cell: s0 inverts B so subtraction is A + ~B + 1 with cin seeded to 1.
    function automatic logic [1:0] full_adder(input logic fa_a, input logic fa_b,
                                              input logic fa_cin, input logic fa_s0);
        logic bx;
        bx = fa_b ^ fa_s0;
        return {(fa_a & bx) | (fa_cin & (fa_a ^ bx)), fa_a ^ bx ^ fa_cin};
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cmsb_q, cmsb_d;
    logic             sub_q, sub_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             neg_q, neg_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             cout_q, cout_d;

    logic [WIDTH-1:0] a_sh_q, b_sh_q;
    logic [WIDTH-2:0] res_sh_q;
    logic             load, shift;

    logic [1:0]       fa_out;
    logic             fa_sum, fa_cout;
    logic [WIDTH-1:0] res_word;
    logic             abort_run;

    always_comb begin
        fa_out   = full_adder(a_sh_q[0], b_sh_q[0], carry_q, sub_q);
        fa_sum   = fa_out[0];
        fa_cout  = fa_out[1];
        res_word = {fa_sum, res_sh_q};
`ifdef SERIAL_ADDSUB_ABORT_EN
        abort_run = abort;
`else
        abort_run = 1'b0;
`endif
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cmsb_d   = cmsb_q;
        sub_d    = sub_q;
        result_d = result_q;
        neg_d    = neg_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        cout_d   = cout_q;
        load     = 1'b0;
        shift    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    sub_d   = op_sub;
                    carry_d = op_sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort_run) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    shift   = 1'b1;
                    carry_d = fa_cout;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == MSB_CIN) begin
                        cmsb_d = fa_cout;
                    end
                    // Final bit: publish result and flags together so an abort never exposes a partial word.
                    if (cnt_q == LAST_BIT) begin
                        cnt_d    = '0;
                        state_d  = DONE;
                        result_d = res_word;
                        neg_d    = res_word[WIDTH-1];
                        zero_d   = (res_word == '0);
                        ovf_d    = cmsb_q ^ fa_cout;
                        cout_d   = fa_cout;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cmsb_q   <= 1'b0;
            sub_q    <= 1'b0;
            result_q <= '0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cmsb_q   <= cmsb_d;
            sub_q    <= sub_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            cout_q   <= cout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            a_sh_q <= a;
            b_sh_q <= b;
        end else if (shift) begin
            a_sh_q   <= a_sh_q >> 1;
            b_sh_q   <= b_sh_q >> 1;
            res_sh_q <= res_word[WIDTH-1:1];
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign negative  = neg_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Scoreboard bench for serial_addsub_seq (WIDTH=8): arithmetic reference model, queued expectations, done-driven monitor.
module tb_serial_addsub_seq;

    localparam int W   = 8;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         op_sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
`ifdef SERIAL_ADDSUB_ABORT_EN
    logic         abort = 1'b0;
`endif
    logic         busy, done, negative, zero, overflow, carry_out;
    logic [W-1:0] result;

    serial_addsub_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op_sub(op_sub), .a(a), .b(b),
`ifdef SERIAL_ADDSUB_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .done(done), .result(result), .negative(negative),
        .zero(zero), .overflow(overflow), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         n, z, v, c;
        int           n0;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    function automatic exp_t model(input logic op, input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input int n0);
        exp_t e;
        int ua, ub, full, sa, sb, sr;
        ua   = int'(av);
        ub   = int'(bv);
        full = op ? ua - ub : ua + ub;
        sa   = int'($signed(av));
        sb   = int'($signed(bv));
        sr   = op ? sa - sb : sa + sb;
        e.res = full[W-1:0];
        e.c   = op ? (ua >= ub) : (full > 255);
        e.v   = (sr > 127) || (sr < -128);
        e.n   = e.res[W-1];
        e.z   = (e.res == '0);
        e.n0  = n0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset && done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 result=%0h expected no pending op", result);
            end else begin
                mon_e = sb_q.pop_front();
                check("result", result, mon_e.res);
                check("negative", negative, mon_e.n);
                check("zero", zero, mon_e.z);
                check("overflow", overflow, mon_e.v);
                check("carry_out", carry_out, mon_e.c);
                check("busy_at_done", busy, 1);
                check("latency", cyc - mon_e.n0 + 1, LAT);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", busy, 0);
    endtask

    task automatic issue(input logic op, input logic [W-1:0] av, input logic [W-1:0] bv, input bit push);
        wait_idle();
        start  = 1'b1;
        op_sub = op;
        a      = av;
        b      = bv;
        @(posedge clk);
        #1;
        if (push) sb_q.push_back(model(op, av, bv, cyc));
        start  = 1'b0;
        op_sub = 1'($urandom);
        a      = W'($urandom);
        b      = W'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", sb_q.size(), 0);
        sb_q.delete();
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] corner [5];
        corner = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
        return W'($urandom);
    endfunction

    initial begin
        int d0, bcyc, g;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_flags", {negative, zero, overflow, carry_out}, 0);
        reset = 1'b1;

        issue(1'b0, 8'h7F, 8'h01, 1); drain();
        issue(1'b1, 8'h05, 8'h05, 1); drain();
        issue(1'b1, 8'h00, 8'h01, 1); drain();
        issue(1'b0, 8'hFF, 8'h01, 1); drain();

        // start held high through RUN/DONE with changing operands
        wait_idle();
        start = 1'b1; op_sub = 1'b0; a = 8'h11; b = 8'h22;
        @(posedge clk); #1;
        sb_q.push_back(model(1'b0, 8'h11, 8'h22, cyc));
        d0 = done_cnt;
        a = 8'h55; b = 8'h66; op_sub = 1'b1;
        bcyc = 0; g = 0;
        do begin
            @(negedge clk);
            if (busy) bcyc++;
            g++;
        end while (!done && g < 30);
        check("busy_cycles", bcyc, LAT);
        @(negedge clk);
        check("held_start_ignored", busy, 0);
        check("single_done", done_cnt - d0, 1);
        @(posedge clk); #1;
        sb_q.push_back(model(1'b1, 8'h55, 8'h66, cyc));
        start = 1'b0;
        drain();

        // asynchronous reset mid-RUN
        issue(1'b0, 8'h12, 8'h34, 1); drain();
        issue(1'b0, 8'h21, 8'h43, 1);
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_result", result, 0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        issue(1'b0, 8'h03, 8'h04, 1); drain();

`ifdef SERIAL_ADDSUB_ABORT_EN
        issue(1'b0, 8'h40, 8'h02, 1); drain();
        d0 = done_cnt;
        issue(1'b0, 8'h10, 8'h20, 0);
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_result", result, 8'h42);
        check("abort_flags", {negative, zero, overflow, carry_out}, 0);
        repeat (12) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        issue(1'b0, 8'h10, 8'h20, 1); drain();
`endif

        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom_range(0, 1)), pick(), pick(), 1);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
